idu: RTL and testbench



---
 rtl/idu_pkg.sv | 48 ++++
 rtl/idu_dec.sv | 92 +++++++++
 rtl/idu.sv | 156 +++++++++++++++
 tb/tb_idu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared decode definitions for the instruction decode stage: opcodes,
// op classes, immediate formats and the WFI encoding.
package idu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] WFI_INS = 32'h10500073;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_ALU_I   = 4'd7,
    CLS_ALU_R   = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } cls_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef enum logic {
    ST_RUN,
    ST_SLEEP
  } state_e;

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I decoder: classifies one instruction word and extracts
// register indices and the format-specific sign-extended immediate.
module idu_dec
  import idu_pkg::*;
(
  input  logic [31:0] ins_i,
  output logic [3:0]  cls_o,
  output logic [2:0]  f3_o,
  output logic        f7b5_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic        ill_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  cls_e       cls;
  imm_fmt_e   fmt;

  assign opc = ins_i[6:0];
  assign f3  = ins_i[14:12];
  assign f7  = ins_i[31:25];

  always_comb begin
    cls = CLS_ILLEGAL;
    fmt = FMT_R;
    unique case (opc)
      OP_LUI:    begin cls = CLS_LUI;    fmt = FMT_U; end
      OP_AUIPC:  begin cls = CLS_AUIPC;  fmt = FMT_U; end
      OP_JAL:    begin cls = CLS_JAL;    fmt = FMT_J; end
      OP_FENCE:  begin cls = CLS_FENCE;  fmt = FMT_I; end
      OP_SYSTEM: begin cls = CLS_SYSTEM; fmt = FMT_I; end
      OP_JALR: begin
        if (f3 == 3'b000) begin cls = CLS_JALR; fmt = FMT_I; end
      end
      OP_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin cls = CLS_BRANCH; fmt = FMT_B; end
      end
      OP_LOAD: begin
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          cls = CLS_LOAD;
          fmt = FMT_I;
        end
      end
      OP_STORE: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
          cls = CLS_STORE;
          fmt = FMT_S;
        end
      end
      // Only the shift-right immediate may carry the 0x20 modifier (SRAI).
      OP_ALU_I: begin
        if (!(f3 == 3'b001 && f7 == 7'h20)) begin cls = CLS_ALU_I; fmt = FMT_I; end
      end
      OP_ALU_R: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          cls = CLS_ALU_R;
          fmt = FMT_R;
        end
      end
      default: ;
    endcase
    if (ins_i[1:0] != 2'b11) begin
      cls = CLS_ILLEGAL;
      fmt = FMT_R;
    end
  end

  always_comb begin
    imm_o = '0;
    unique case (fmt)
      FMT_I: imm_o = {{20{ins_i[31]}}, ins_i[31:20]};
      FMT_S: imm_o = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      FMT_B: imm_o = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      FMT_U: imm_o = {ins_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

  assign cls_o  = cls;
  assign ill_o  = (cls == CLS_ILLEGAL);
  assign f3_o   = f3;
  assign f7b5_o = ins_i[30];
  assign rs1_o  = ins_i[19:15];
  assign rs2_o  = ins_i[24:20];
  assign rd_o   = ins_i[11:7];

endmodule

// File: rtl/idu.sv
// Decode stage: 2-entry skid FIFO between fetch and ALU, RV32I decode of the
// head entry, WFI sleep handshake and branch flush.
module idu
  import idu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_idu_vld,
  input  logic [31:0]     ifu_idu_ins,
  input  logic [PC_W-1:0] ifu_idu_pc,
  output logic            idu_ifu_rdy,
  output logic            idu_ifu_wfi,
  input  logic            idu_wake,
  input  logic            alu_ifu_br_vld,
  output logic            idu_alu_vld,
  input  logic            idu_alu_rdy,
  output logic [3:0]      idu_alu_cls,
  output logic [2:0]      idu_alu_f3,
  output logic            idu_alu_f7b5,
  output logic [4:0]      idu_alu_rs1,
  output logic [4:0]      idu_alu_rs2,
  output logic [4:0]      idu_alu_rd,
  output logic [31:0]     idu_alu_imm,
  output logic [PC_W-1:0] idu_alu_pc,
  output logic            idu_alu_ill
);

  typedef struct packed {
    logic [31:0]     ins;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t       ent0_q, ent0_d, ent1_q, ent1_d, beat;
  logic [1:0] cnt_q, cnt_d;
  state_e     st_q, st_d;
  logic       wfi_q, wfi_d;
  logic       acc, push, pop, wfi_acc;

  logic [3:0]  dec_cls;
  logic [2:0]  dec_f3;
  logic        dec_f7b5, dec_ill;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;

  assign beat        = '{ins: ifu_idu_ins, pc: ifu_idu_pc};
  assign idu_ifu_rdy = (cnt_q != 2'(BUF_DEPTH)) && (st_q == ST_RUN);
  assign idu_ifu_wfi = wfi_q;
  assign idu_alu_vld = (cnt_q != 2'd0);

  assign acc     = ifu_idu_vld & idu_ifu_rdy & ~alu_ifu_br_vld;
  assign wfi_acc = acc & (ifu_idu_ins == WFI_INS);
  assign push    = acc & (ifu_idu_ins != WFI_INS);
  assign pop     = idu_alu_vld & idu_alu_rdy;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (alu_ifu_br_vld) begin
      cnt_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = beat;
          else               ent1_d = beat;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = beat;
          end else begin
            ent0_d = ent1_q;
            ent1_d = beat;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d  = st_q;
    wfi_d = wfi_acc;
    unique case (st_q)
      ST_RUN:   if (wfi_acc && !idu_wake) st_d = ST_SLEEP;
      ST_SLEEP: if (idu_wake)             st_d = ST_RUN;
      default:  st_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_RUN;
      wfi_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      wfi_q <= wfi_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  idu_dec u_dec (
    .ins_i  (ent0_q.ins),
    .cls_o  (dec_cls),
    .f3_o   (dec_f3),
    .f7b5_o (dec_f7b5),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd),
    .imm_o  (dec_imm),
    .ill_o  (dec_ill)
  );

  always_comb begin
    idu_alu_cls  = '0;
    idu_alu_f3   = '0;
    idu_alu_f7b5 = 1'b0;
    idu_alu_rs1  = '0;
    idu_alu_rs2  = '0;
    idu_alu_rd   = '0;
    idu_alu_imm  = '0;
    idu_alu_pc   = '0;
    idu_alu_ill  = 1'b0;
    if (idu_alu_vld) begin
      idu_alu_cls  = dec_cls;
      idu_alu_f3   = dec_f3;
      idu_alu_f7b5 = dec_f7b5;
      idu_alu_rs1  = dec_rs1;
      idu_alu_rs2  = dec_rs2;
      idu_alu_rd   = dec_rd;
      idu_alu_imm  = dec_imm;
      idu_alu_pc   = ent0_q.pc;
      idu_alu_ill  = dec_ill;
    end
  end

endmodule

// File: tb/tb_idu.sv
// Directed bench for the decode stage: handshake, skid buffering, decode
// classes/immediates, flush, WFI sleep/wake and illegal forwarding.
module tb_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_idu_vld;
  logic [31:0] ifu_idu_ins;
  logic [31:0] ifu_idu_pc;
  logic        idu_ifu_rdy;
  logic        idu_ifu_wfi;
  logic        idu_wake;
  logic        alu_ifu_br_vld;
  logic        idu_alu_vld;
  logic        idu_alu_rdy;
  logic [3:0]  idu_alu_cls;
  logic [2:0]  idu_alu_f3;
  logic        idu_alu_f7b5;
  logic [4:0]  idu_alu_rs1;
  logic [4:0]  idu_alu_rs2;
  logic [4:0]  idu_alu_rd;
  logic [31:0] idu_alu_imm;
  logic [31:0] idu_alu_pc;
  logic        idu_alu_ill;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idu #(.PC_W(32), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_idu_vld    (ifu_idu_vld),
    .ifu_idu_ins    (ifu_idu_ins),
    .ifu_idu_pc     (ifu_idu_pc),
    .idu_ifu_rdy    (idu_ifu_rdy),
    .idu_ifu_wfi    (idu_ifu_wfi),
    .idu_wake       (idu_wake),
    .alu_ifu_br_vld (alu_ifu_br_vld),
    .idu_alu_vld    (idu_alu_vld),
    .idu_alu_rdy    (idu_alu_rdy),
    .idu_alu_cls    (idu_alu_cls),
    .idu_alu_f3     (idu_alu_f3),
    .idu_alu_f7b5   (idu_alu_f7b5),
    .idu_alu_rs1    (idu_alu_rs1),
    .idu_alu_rs2    (idu_alu_rs2),
    .idu_alu_rd     (idu_alu_rd),
    .idu_alu_imm    (idu_alu_imm),
    .idu_alu_pc     (idu_alu_pc),
    .idu_alu_ill    (idu_alu_ill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    ifu_idu_vld = 1'b1;
    ifu_idu_ins = ins;
    ifu_idu_pc  = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifu_idu_vld = 1'b0; ifu_idu_ins = '0; ifu_idu_pc = '0;
    idu_wake = 1'b0; alu_ifu_br_vld = 1'b0; idu_alu_rdy = 1'b0;
    tick(); tick();
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", idu_ifu_rdy); end
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", idu_alu_vld); end
    checks++; if (idu_ifu_wfi !== 1'b0) begin failures++; $display("FAIL reset_wfi got=%b exp=0", idu_ifu_wfi); end
    checks++; if (idu_alu_imm !== 32'h0) begin failures++; $display("FAIL reset_imm got=%h exp=0", idu_alu_imm); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    idu_alu_rdy = 1'b1;
    offer(32'h00500093, 32'h100);
    tick();
    ifu_idu_vld = 1'b0;
    checks++; if (idu_alu_vld !== 1'b1) begin failures++; $display("FAIL addi_vld got=%b exp=1", idu_alu_vld); end
    checks++; if (idu_alu_cls !== 4'd7) begin failures++; $display("FAIL addi_cls got=%0d exp=7", idu_alu_cls); end
    checks++; if (idu_alu_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", idu_alu_rd); end
    checks++; if (idu_alu_rs1 !== 5'd0) begin failures++; $display("FAIL addi_rs1 got=%0d exp=0", idu_alu_rs1); end
    checks++; if (idu_alu_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", idu_alu_imm); end
    checks++; if (idu_alu_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", idu_alu_pc); end
    checks++; if (idu_alu_ill !== 1'b0) begin failures++; $display("FAIL addi_ill got=%b exp=0", idu_alu_ill); end
    tick();
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL addi_drain_vld got=%b exp=0", idu_alu_vld); end
    checks++; if (idu_alu_pc !== 32'h0) begin failures++; $display("FAIL addi_zero_pc got=%h exp=0", idu_alu_pc); end
  endtask

  task automatic test_backpressure();
    idu_alu_rdy = 1'b0;
    offer(32'h00100093, 32'h200);
    tick();
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy1 got=%b exp=1", idu_ifu_rdy); end
    offer(32'h00200113, 32'h204);
    tick();
    checks++; if (idu_ifu_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_full got=%b exp=0", idu_ifu_rdy); end
    offer(32'h00300193, 32'h208);
    tick();
    checks++; if (idu_ifu_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_hold got=%b exp=0", idu_ifu_rdy); end
    checks++; if (idu_alu_pc !== 32'h200) begin failures++; $display("FAIL bp_head_stable got=%h exp=200", idu_alu_pc); end
    checks++; if (idu_alu_imm !== 32'd1) begin failures++; $display("FAIL bp_head_imm got=%h exp=1", idu_alu_imm); end
    ifu_idu_vld = 1'b0;
    idu_alu_rdy = 1'b1;
    tick();
    checks++; if (idu_alu_pc !== 32'h204) begin failures++; $display("FAIL bp_second_pc got=%h exp=204", idu_alu_pc); end
    checks++; if (idu_alu_rd !== 5'd2) begin failures++; $display("FAIL bp_second_rd got=%0d exp=2", idu_alu_rd); end
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_back got=%b exp=1", idu_ifu_rdy); end
    tick();
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL bp_third_dropped got=%b exp=0", idu_alu_vld); end
  endtask

  task automatic test_formats();
    idu_alu_rdy = 1'b1;
    offer(32'hFE000CE3, 32'h300);
    tick();
    checks++; if (idu_alu_cls !== 4'd4) begin failures++; $display("FAIL beq_cls got=%0d exp=4", idu_alu_cls); end
    checks++; if (idu_alu_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL beq_imm got=%h exp=fffffff8", idu_alu_imm); end
    offer(32'h0020A623, 32'h304);
    tick();
    ifu_idu_vld = 1'b0;
    checks++; if (idu_alu_cls !== 4'd6) begin failures++; $display("FAIL sw_cls got=%0d exp=6", idu_alu_cls); end
    checks++; if (idu_alu_imm !== 32'd12) begin failures++; $display("FAIL sw_imm got=%h exp=c", idu_alu_imm); end
    checks++; if ({idu_alu_rs1, idu_alu_rs2, idu_alu_f3} !== {5'd1, 5'd2, 3'd2}) begin
      failures++; $display("FAIL sw_fields got=%0d/%0d/%0d exp=1/2/2", idu_alu_rs1, idu_alu_rs2, idu_alu_f3);
    end
    checks++; if (idu_alu_pc !== 32'h304) begin failures++; $display("FAIL sw_pc got=%h exp=304", idu_alu_pc); end
    tick();
  endtask

  task automatic test_flush();
    idu_alu_rdy = 1'b0;
    offer(32'h00100093, 32'h400); tick();
    offer(32'h00200113, 32'h404); tick();
    alu_ifu_br_vld = 1'b1;
    offer(32'h00300193, 32'h408);
    tick();
    alu_ifu_br_vld = 1'b0; ifu_idu_vld = 1'b0;
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL flush_full_vld got=%b exp=0", idu_alu_vld); end
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL flush_full_rdy got=%b exp=1", idu_ifu_rdy); end
    idu_alu_rdy = 1'b1;
    offer(32'h00100093, 32'h500); tick();
    alu_ifu_br_vld = 1'b1;
    offer(32'h00200113, 32'h504);
    tick();
    alu_ifu_br_vld = 1'b0; ifu_idu_vld = 1'b0;
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL flush_beat_vld got=%b exp=0", idu_alu_vld); end
    tick();
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL flush_beat_late got=%b exp=0", idu_alu_vld); end
  endtask

  task automatic test_wfi();
    idu_alu_rdy = 1'b1;
    offer(32'h10500073, 32'h600);
    tick();
    ifu_idu_vld = 1'b0;
    checks++; if (idu_ifu_wfi !== 1'b1) begin failures++; $display("FAIL wfi_pulse got=%b exp=1", idu_ifu_wfi); end
    checks++; if (idu_ifu_rdy !== 1'b0) begin failures++; $display("FAIL wfi_rdy got=%b exp=0", idu_ifu_rdy); end
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL wfi_not_pushed got=%b exp=0", idu_alu_vld); end
    tick();
    checks++; if (idu_ifu_wfi !== 1'b0) begin failures++; $display("FAIL wfi_pulse_end got=%b exp=0", idu_ifu_wfi); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (idu_ifu_rdy !== 1'b0) begin failures++; $display("FAIL wfi_sleep_rdy[%0d] got=%b exp=0", i, idu_ifu_rdy); end
    end
    idu_wake = 1'b1;
    tick();
    idu_wake = 1'b0;
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL wfi_wake_rdy got=%b exp=1", idu_ifu_rdy); end

    alu_ifu_br_vld = 1'b1;
    offer(32'h10500073, 32'h610);
    tick();
    alu_ifu_br_vld = 1'b0; ifu_idu_vld = 1'b0;
    checks++; if ({idu_ifu_wfi, idu_ifu_rdy} !== 2'b01) begin failures++; $display("FAIL wfi_flush got=%b exp=01", {idu_ifu_wfi, idu_ifu_rdy}); end

    idu_wake = 1'b1;
    offer(32'h10500073, 32'h620);
    tick();
    idu_wake = 1'b0; ifu_idu_vld = 1'b0;
    checks++; if ({idu_ifu_wfi, idu_ifu_rdy} !== 2'b11) begin failures++; $display("FAIL wfi_wake_same got=%b exp=11", {idu_ifu_wfi, idu_ifu_rdy}); end

    idu_alu_rdy = 1'b0;
    offer(32'h00100093, 32'h700); tick();
    offer(32'h10500073, 32'h704); tick();
    ifu_idu_vld = 1'b0;
    checks++; if ({idu_ifu_wfi, idu_alu_vld, idu_ifu_rdy} !== 3'b110) begin
      failures++; $display("FAIL wfi_drain_state got=%b exp=110", {idu_ifu_wfi, idu_alu_vld, idu_ifu_rdy});
    end
    checks++; if (idu_alu_pc !== 32'h700) begin failures++; $display("FAIL wfi_drain_pc got=%h exp=700", idu_alu_pc); end
    idu_alu_rdy = 1'b1;
    tick();
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL wfi_drained got=%b exp=0", idu_alu_vld); end
    idu_wake = 1'b1;
    tick();
    idu_wake = 1'b0;
  endtask

  task automatic test_illegal();
    idu_alu_rdy = 1'b1;
    offer(32'h0000007F, 32'h800); tick();
    checks++; if ({idu_alu_ill, idu_alu_cls} !== {1'b1, 4'd11}) begin failures++; $display("FAIL ill_7f got=%b/%0d exp=1/11", idu_alu_ill, idu_alu_cls); end
    offer(32'hFFFFFFFF, 32'h804); tick();
    checks++; if ({idu_alu_ill, idu_alu_cls} !== {1'b1, 4'd11}) begin failures++; $display("FAIL ill_ff got=%b/%0d exp=1/11", idu_alu_ill, idu_alu_cls); end
    checks++; if (idu_alu_pc !== 32'h804) begin failures++; $display("FAIL ill_ff_pc got=%h exp=804", idu_alu_pc); end
    offer(32'h002081B3, 32'h808); tick();
    checks++; if ({idu_alu_ill, idu_alu_cls} !== {1'b0, 4'd8}) begin failures++; $display("FAIL add_cls got=%b/%0d exp=0/8", idu_alu_ill, idu_alu_cls); end
    checks++; if ({idu_alu_rd, idu_alu_rs1, idu_alu_rs2} !== {5'd3, 5'd1, 5'd2}) begin
      failures++; $display("FAIL add_regs got=%0d/%0d/%0d exp=3/1/2", idu_alu_rd, idu_alu_rs1, idu_alu_rs2);
    end
    checks++; if (idu_alu_imm !== 32'h0) begin failures++; $display("FAIL add_imm got=%h exp=0", idu_alu_imm); end
    offer(32'h40209133, 32'h80C); tick();
    checks++; if (idu_alu_ill !== 1'b1) begin failures++; $display("FAIL sll_f7_ill got=%b exp=1", idu_alu_ill); end
    offer(32'h40208133, 32'h810); tick();
    ifu_idu_vld = 1'b0;
    checks++; if ({idu_alu_ill, idu_alu_cls, idu_alu_f7b5} !== {1'b0, 4'd8, 1'b1}) begin
      failures++; $display("FAIL sub_ok got=%b/%0d/%b exp=0/8/1", idu_alu_ill, idu_alu_cls, idu_alu_f7b5);
    end
    tick();
  endtask

  task automatic test_async_reset();
    idu_alu_rdy = 1'b0;
    offer(32'h00100093, 32'h900); tick();
    ifu_idu_vld = 1'b0;
    checks++; if (idu_alu_vld !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", idu_alu_vld); end
    #2 rst = 1'b1;
    #1;
    checks++; if (idu_alu_vld !== 1'b0) begin failures++; $display("FAIL arst_vld got=%b exp=0", idu_alu_vld); end
    checks++; if (idu_ifu_rdy !== 1'b1) begin failures++; $display("FAIL arst_rdy got=%b exp=1", idu_ifu_rdy); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_formats();
    test_flush();
    test_wfi();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
